imm_extend_pipe: RTL

Parametrised, pipelined immediate-extension unit for the CPU decode stage. It takes an IN_W-bit instruction immediate and produces an OUT_W-bit operand in one of four modes: zero-extend, sign-extend, sign-extend-and-shift (branch offsets) and load-upper. Both sides use a valid/ready handshake. A 2-entry output buffer gives one-cycle latency, full throughput and a registered in_ready.

---
 rtl/imm_extend_pipe_if.sv | 30 +++
 rtl/imm_extend_pipe.sv | 139 +++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// imm_extend_pipe_if : valid/ready bus for the immediate-extension unit
// Rev 1.0
// ============================================================================
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    // master drives immediates and consumes results; slave is the extension unit
    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// imm_extend_pipe : pipelined zero/sign/branch/load-upper immediate extension
// Rev 1.0
// ============================================================================
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    imm_extend_pipe_if.slave   bus
);
    localparam int WIDE_W = OUT_W + BR_SHIFT;

    generate
        if (IN_W < 2 || OUT_W < IN_W || BR_SHIFT < 0 || BR_SHIFT >= OUT_W) begin : g_bad_params
            $error("imm_extend_pipe: illegal IN_W/OUT_W/BR_SHIFT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_head_data;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_head_ovf;
    logic             r_skid_ovf;
    logic [OUT_W-1:0] w_res_data;
    logic             w_res_ovf;
    logic [WIDE_W-1:0] w_wide;
    logic [BR_SHIFT:0] w_top;
    logic             w_push;
    logic             w_pop;
    logic             w_load_head_new;
    logic             w_load_skid_new;
    logic             w_load_head_skid;

    assign w_push = bus.in_valid & r_in_ready;
    assign w_pop  = r_out_valid & bus.out_ready;

    // Branch offset: no overflow iff the dropped bits and the new sign bit agree
    assign w_wide = WIDE_W'($signed(bus.in_imm)) << BR_SHIFT;
    assign w_top  = w_wide[WIDE_W-1 -: BR_SHIFT+1];

    always_comb begin
        w_res_data = '0;
        w_res_ovf  = 1'b0;
        case (bus.in_mode)
            2'd0:    w_res_data = OUT_W'(bus.in_imm);
            2'd1:    w_res_data = OUT_W'($signed(bus.in_imm));
            2'd2: begin
                w_res_data = w_wide[OUT_W-1:0];
                w_res_ovf  = !((&w_top) || !(|w_top));
            end
            default: w_res_data = OUT_W'(bus.in_imm) << (OUT_W - IN_W);
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_new  = 1'b0;
        w_load_skid_new  = 1'b0;
        w_load_head_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt     = ST_ONE;
                    w_load_head_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_load_head_new = 1'b1;
                end else if (w_push) begin
                    w_state_nxt     = ST_FULL;
                    w_load_skid_new = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = ST_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so neither has a combinational path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_data <= '0;
            r_head_ovf  <= 1'b0;
            r_skid_data <= '0;
            r_skid_ovf  <= 1'b0;
        end else begin
            if (w_load_head_new) begin
                r_head_data <= w_res_data;
                r_head_ovf  <= w_res_ovf;
            end else if (w_load_head_skid) begin
                r_head_data <= r_skid_data;
                r_head_ovf  <= r_skid_ovf;
            end
            if (w_load_skid_new) begin
                r_skid_data <= w_res_data;
                r_skid_ovf  <= w_res_ovf;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_head_data;
    assign bus.out_ovf   = r_head_ovf;
endmodule
`default_nettype wire
